line_buffer_window: RTL and testbench
=====================================

Name: line_buffer_window

Overview:
- Parametrised successor to the single line-FIFO stage: a complete KERNEL_SIZE x KERNEL_SIZE sliding-window generator for a raster pixel stream.
- Contains KERNEL_SIZE-1 internal line memories plus a KxK window register, with tracked column and row counters and per-window border detection.
- Sits between the pixel source and the kernel datapath (gradient/HOG cell stages). Supports backpressure on both sides.

Parameters:
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 854, pixels per line (>= KERNEL_SIZE)
- IMG_HEIGHT, 480, lines per frame (>= KERNEL_SIZE)
- KERNEL_SIZE, 3, window edge length (2..7)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_WIDTH  pixel, raster order
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts pixel this cycle
- win_data  output  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  window, element (r,c) at [(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 top/oldest row, c=0 leftmost/oldest column
- out_valid  output  1  win_data valid
- out_ready  input  1  consumer accepts window
- border_flag  output  1  window straddles a line or frame edge; contents are invalid
- frame_last  output  1  window belongs to last pixel of frame
- col_cnt  output  $clog2(IMG_WIDTH)  column of the next pixel to be accepted
- row_cnt  output  $clog2(IMG_HEIGHT)  row of the next pixel to be accepted

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - out_valid=0, border_flag=0, frame_last=0, col_cnt=0, row_cnt=0, win_data=0.
  - Line memory contents are not reset.
- Handshake:
  - accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so one output register stage with no skid.
  - Window is held stable while out_valid && !out_ready.
- Latency:
  - A pixel accepted at edge N produces its window, with out_valid=1, in the cycle after edge N.
  - Sustained throughput is 1 pixel/clk when out_ready=1.
- On accept of pixel p at (row_cnt=R, col_cnt=C):
  - The column vector {pix(R-K+1,C) .. pix(R-1,C), p} is shifted into the window at c=K-1; existing columns shift toward c=0.
  - p is written into the line memory for column C, and older rows shift up one line.
  - The column read for C and the write of p must not interfere: read-before-write at the same address.
- Counters:
  - col_cnt increments on accept and wraps IMG_WIDTH-1 -> 0.
  - row_cnt increments on col wrap and wraps IMG_HEIGHT-1 -> 0, starting the next frame.
- border_flag = (R < K-1) || (C < K-1), registered alongside win_data.
  - These windows contain data from the previous line or frame, or uninitialised memory.
- frame_last = (R == IMG_HEIGHT-1) && (C == IMG_WIDTH-1), registered alongside win_data.
- Output handling:
  - out_valid falls when out_ready=1 and there was no accept on that edge.
  - Simultaneous output consume and input accept keeps out_valid=1 with the new window.
- Wrap-around:
  - No bubble at line or frame wrap.
  - Frame N+1 row 0 windows carry border_flag=1; no explicit flush is required.
- Reset mid-frame:
  - All counters return to 0 and out_valid drops immediately.
  - The first K-1 rows after reset are flagged as border.

Optional Feature:
- Macro: LINE_BUFFER_SKIP_BORDER_EN.
- Defined: border windows are consumed internally and never presented.
  - out_valid stays 0 for them, and in_ready stays governed by the output-stage rule.
  - Exactly (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) windows are emitted per frame.
  - border_flag is tied to 0.
- Undefined: every accepted pixel produces one window, flagged per the border_flag rule above.

Test Plan:
- Setup for all tests: IMG_WIDTH=6, IMG_HEIGHT=4, KERNEL_SIZE=3, pixel value = row*16+col.
- Continuous stream of 24 pixels, out_ready=1 -> 24 windows. Window for (2,2) has (0,0)=0x00, (0,2)=0x02, (2,0)=0x20, (2,2)=0x22 with border_flag=0. Windows at (1,5) and (2,1) have border_flag=1.
- Border count over the full frame -> exactly 8 windows with border_flag=0. frame_last=1 only on the window for (3,5), whose (0,0)=0x13.
- out_ready held low 5 cycles during row 2 -> in_ready=0, win_data and out_valid stable. No pixel lost or duplicated; the window sequence matches the no-stall run.
- Two back-to-back frames (second frame pixel = 0x80 + row*16+col) -> frame-2 (0,*) and (1,*) windows border_flag=1. Frame-2 (2,2) window (0,0)=0x80.
- rst_n pulsed low mid-row 2 -> out_valid=0, col_cnt=row_cnt=0 asynchronously. The following frame is reproduced exactly as in the first test.
- LINE_BUFFER_SKIP_BORDER_EN defined, continuous frame -> exactly 8 out_valid pulses, the first carrying bottom-right 0x22 and the last 0x35.

Source files
------------

// File: rtl/line_buffer_window_if.sv
// ----------------------------------------------------------------------------
// line_buffer_window_if
//   Groups the pixel-in and window-out handshake signals of line_buffer_window.
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both high. The sender holds data and valid
//   stable until that edge. ready may depend on the receiver's state only.
//
//   Signals
//     in_data     pixel from the source, raster order
//     in_valid    in_data is valid
//     in_ready    block accepts a pixel this cycle
//     win_data    KxK window, element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
//     out_valid   win_data is valid
//     out_ready   consumer accepts the window
//     border_flag window straddles a line or frame edge (contents invalid)
//     frame_last  window belongs to the last pixel of the frame
//
//   Modports
//     master  pixel source plus window consumer (the environment)
//     slave   the window generator itself
// ----------------------------------------------------------------------------
interface line_buffer_window_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3
);
    logic [DATA_WIDTH-1:0]                         in_data;
    logic                                          in_valid;
    logic                                          in_ready;
    logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data;
    logic                                          out_valid;
    logic                                          out_ready;
    logic                                          border_flag;
    logic                                          frame_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, win_data, out_valid, border_flag, frame_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, win_data, out_valid, border_flag, frame_last
    );
endinterface

// File: rtl/line_buffer_window.sv
// ----------------------------------------------------------------------------
// line_buffer_window
//   KERNEL_SIZE x KERNEL_SIZE sliding-window generator for a raster pixel
//   stream. KERNEL_SIZE-1 line memories hold the previous rows; on every
//   accepted pixel the column {older rows .. new pixel} is shifted into the
//   right edge of the window register. One registered output stage, no skid.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     lb           line_buffer_window_if.slave (pixel in, window out)
//     col_cnt      column of the next pixel to be accepted
//     row_cnt      row of the next pixel to be accepted
//
//   Build option
//     LINE_BUFFER_SKIP_BORDER_EN  when defined, border windows are consumed
//                                 internally and never presented; border_flag
//                                 then stays 0.
// ----------------------------------------------------------------------------
module line_buffer_window #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 854,
    parameter int IMG_HEIGHT  = 480,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    line_buffer_window_if.slave           lb,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_cnt,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_cnt
);
    localparam int K  = KERNEL_SIZE;
    localparam int NL = KERNEL_SIZE - 1;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

`ifdef LINE_BUFFER_SKIP_BORDER_EN
    localparam bit SKIP_BORDER = 1'b1;
`else
    localparam bit SKIP_BORDER = 1'b0;
`endif

    // lm_q[0] holds the oldest row (R-K+1), lm_q[NL-1] the row just above R.
    logic [DATA_WIDTH-1:0] lm_q [NL][IMG_WIDTH];

    logic [DATA_WIDTH-1:0] win_q [K][K];
    logic [DATA_WIDTH-1:0] win_d [K][K];
    logic [DATA_WIDTH-1:0] col_vec [K];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          out_valid_q, out_valid_d;
    logic          border_q, border_d;
    logic          last_q, last_d;

    logic accept;
    logic is_border;
    logic is_last;
    logic present;

    logic [K*K*DATA_WIDTH-1:0] win_flat;

    // Single output register: a new pixel may enter whenever the held window
    // is absent or being consumed on the same edge.
    assign lb.in_ready = !out_valid_q || lb.out_ready;
    assign accept      = lb.in_valid && lb.in_ready;

    assign is_border = (row_q < RW'(K - 1)) || (col_q < CW'(K - 1));
    assign is_last   = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
    assign present   = !(SKIP_BORDER && is_border);

    // Column entering the window. The memory read sees the pre-edge contents,
    // so the write of the new pixel to the same address cannot disturb it.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            col_vec[r] = '0;
        end
        for (int r = 0; r < NL; r++) begin
            col_vec[r] = lm_q[r][col_q];
        end
        col_vec[K-1] = lb.in_data;
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_vec[r];
            end
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_HEIGHT - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        border_d    = border_q;
        last_d      = last_q;
        if (accept) begin
            out_valid_d = present;
            border_d    = is_border && !SKIP_BORDER;
            last_d      = is_last;
        end else if (lb.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Line memories carry no reset; stale rows only ever reach border windows.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NL - 1; i++) begin
                lm_q[i][col_q] <= lm_q[i+1][col_q];
            end
            lm_q[NL-1][col_q] <= lb.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            border_q    <= 1'b0;
            last_q      <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            border_q    <= border_d;
            last_q      <= last_d;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
            end
        end
    end

    assign lb.win_data    = win_flat;
    assign lb.out_valid   = out_valid_q;
    assign lb.border_flag = border_q;
    assign lb.frame_last  = last_q;
    assign col_cnt        = col_q;
    assign row_cnt        = row_q;

endmodule

// File: tb/tb_line_buffer_window.sv
module tb_line_buffer_window;
    localparam int DW   = 8;
    localparam int W    = 6;
    localparam int H    = 4;
    localparam int K    = 3;
    localparam int NPIX = W * H;
    localparam int WINW = K * K * DW;
    // expected entry: {idx[5:0], chk_win, last, border, win}
    localparam int EW   = WINW + 3 + 6;

`ifdef LINE_BUFFER_SKIP_BORDER_EN
    localparam bit SKIP     = 1'b1;
    localparam int WIN_PER_FRAME = 8;
`else
    localparam bit SKIP     = 1'b0;
    localparam int WIN_PER_FRAME = 24;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_window_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) lb ();
    logic [2:0] col_cnt;
    logic [1:0] row_cnt;

    line_buffer_window #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lb      (lb),
        .col_cnt (col_cnt),
        .row_cnt (row_cnt)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] img [H][W];
    int mr = 0, mc = 0, mf = 0;

    logic [WINW-1:0] cap_win    [2*NPIX];
    logic            cap_border [2*NPIX];
    logic            cap_last   [2*NPIX];
    logic            cap_seen   [2*NPIX];

    logic rdy_mode  = 1'b0;
    logic rdy_force = 1'b1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] elem(input logic [WINW-1:0] w, input int r, input int c);
        return w[(r*K+c)*DW +: DW];
    endfunction

    // out_ready is owned by this process only
    always @(posedge clk) begin
        #2;
        lb.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0]   mon_e;
    logic [WINW-1:0] mon_w;
    int              mon_idx;
    logic            mon_b, mon_l;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lb.out_valid && lb.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_idx = int'(mon_e[WINW+8:WINW+3]);
                    chk("border_flag", lb.border_flag, mon_e[WINW]);
                    chk("frame_last", lb.frame_last, mon_e[WINW+1]);
                    if (mon_e[WINW+2]) chk("win_data", lb.win_data, mon_e[WINW-1:0]);
                    cap_win[mon_idx]    = lb.win_data;
                    cap_border[mon_idx] = lb.border_flag;
                    cap_last[mon_idx]   = lb.frame_last;
                    cap_seen[mon_idx]   = 1'b1;
                end
            end
            if (lb.in_valid && lb.in_ready) begin
                chk("col_cnt", col_cnt, mc);
                chk("row_cnt", row_cnt, mr);
                img[mr][mc] = lb.in_data;
                mon_b = (mr < K - 1) || (mc < K - 1);
                mon_l = (mr == H - 1) && (mc == W - 1);
                mon_w = '0;
                if (!mon_b) begin
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            mon_w[(r*K+c)*DW +: DW] = img[mr-K+1+r][mc-K+1+c];
                end
                if (!(SKIP && mon_b)) begin
                    mon_idx = (mf % 2) * NPIX + mr * W + mc;
                    exp_q.push_back({6'(mon_idx), !mon_b, mon_l, mon_b && !SKIP, mon_w});
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr++;
                    if (mr == H) begin
                        mr = 0;
                        mf++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [DW-1:0] d);
        int t;
        t = 0;
        lb.in_data  = d;
        lb.in_valid = 1'b1;
        @(negedge clk);
        while (!lb.in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!lb.in_ready) chk("push_timeout", 1, 0);
        @(posedge clk);
        #1;
        lb.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit rnd);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (rnd) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    push(DW'($urandom_range(0, 255)));
                end else begin
                    push(base + DW'(r * 16 + c));
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clr_cap();
        for (int i = 0; i < 2 * NPIX; i++) cap_seen[i] = 1'b0;
        mf = 0;
    endtask

    task automatic counts(input int base);
        int nb, ls, tot;
        nb = 0; ls = 0; tot = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (cap_seen[base+i]) begin
                tot++;
                if (!cap_border[base+i]) nb++;
                if (cap_last[base+i]) ls++;
            end
        end
        chk("nonborder_count", nb, 8);
        chk("frame_last_count", ls, 1);
        chk("window_count", tot, WIN_PER_FRAME);
    endtask

    // ---------------- table-driven checks ----------------
    typedef struct {
        int         r;
        int         c;
        int         er;
        int         ec;
        logic [7:0] val;
        logic       chk_val;
        logic       border;
        logic       last;
    } vec_t;

    vec_t tab [11];

    task automatic check_table(input int base);
        int p;
        for (int i = 0; i < 11; i++) begin
            p = base + tab[i].r * W + tab[i].c;
            if (SKIP && tab[i].border) begin
                chk("skip_border_hidden", cap_seen[p], 0);
            end else begin
                chk("tab_seen", cap_seen[p], 1);
                chk("tab_border", cap_border[p], tab[i].border);
                chk("tab_last", cap_last[p], tab[i].last);
                if (tab[i].chk_val)
                    chk("tab_elem", elem(cap_win[p], tab[i].er, tab[i].ec), tab[i].val);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    logic [WINW-1:0] saved;

    initial begin
        tab[0]  = '{2, 2, 0, 0, 8'h00, 1'b1, 1'b0, 1'b0};
        tab[1]  = '{2, 2, 0, 2, 8'h02, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{2, 2, 2, 0, 8'h20, 1'b1, 1'b0, 1'b0};
        tab[3]  = '{2, 2, 2, 2, 8'h22, 1'b1, 1'b0, 1'b0};
        tab[4]  = '{1, 5, 0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        tab[5]  = '{2, 1, 0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        tab[6]  = '{3, 5, 0, 0, 8'h13, 1'b1, 1'b0, 1'b1};
        tab[7]  = '{3, 5, 2, 2, 8'h35, 1'b1, 1'b0, 1'b1};
        tab[8]  = '{0, 0, 0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        tab[9]  = '{2, 5, 0, 0, 8'h03, 1'b1, 1'b0, 1'b0};
        tab[10] = '{3, 2, 1, 1, 8'h21, 1'b1, 1'b0, 1'b0};

        lb.in_valid = 1'b0;
        lb.in_data  = '0;
        rst_n = 1'b0;
        clr_cap();
        #2;
        chk("rst_out_valid", lb.out_valid, 0);
        chk("rst_border", lb.border_flag, 0);
        chk("rst_frame_last", lb.frame_last, 0);
        chk("rst_col_cnt", col_cnt, 0);
        chk("rst_row_cnt", row_cnt, 0);
        chk("rst_win_data", lb.win_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // continuous frame
        clr_cap();
        send_frame(8'h00, 1'b0);
        drain();
        check_table(0);
        counts(0);

        // output stall during row 2
        clr_cap();
        for (int i = 0; i < 14; i++) push(DW'((i / W) * 16 + (i % W)));
        rdy_force   = 1'b0;
        lb.in_data  = 8'h22;
        lb.in_valid = 1'b1;
        @(negedge clk);
        saved = lb.win_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", lb.in_ready, 0);
            chk("stall_out_valid", lb.out_valid, 1);
            chk("stall_win_stable", lb.win_data, saved);
            chk("stall_col_cnt", col_cnt, 2);
        end
        rdy_force = 1'b1;
        for (int i = 14; i < NPIX; i++) push(DW'((i / W) * 16 + (i % W)));
        drain();
        check_table(0);
        counts(0);

        // two back-to-back frames
        clr_cap();
        send_frame(8'h00, 1'b0);
        send_frame(8'h80, 1'b0);
        drain();
        for (int i = 0; i < 2 * W; i++) begin
            if (SKIP) chk("f2_border_hidden", cap_seen[NPIX+i], 0);
            else      chk("f2_border_flag", cap_border[NPIX+i], 1);
        end
        chk("f2_22_tl", elem(cap_win[NPIX+2*W+2], 0, 0), 8'h80);
        chk("f2_22_br", elem(cap_win[NPIX+2*W+2], 2, 2), 8'hA2);
        counts(0);
        counts(NPIX);

        // reset mid-row 2
        clr_cap();
        for (int i = 0; i < 14; i++) push(DW'((i / W) * 16 + (i % W)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", lb.out_valid, 0);
        chk("mid_rst_col_cnt", col_cnt, 0);
        chk("mid_rst_row_cnt", row_cnt, 0);
        exp_q.delete();
        mr = 0;
        mc = 0;
        clr_cap();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(8'h00, 1'b0);
        drain();
        check_table(0);
        counts(0);

        // random data, gaps and backpressure
        clr_cap();
        rdy_mode = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1);
        drain();
        rdy_mode = 1'b0;
        counts(0);
        counts(NPIX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end
endmodule
